// File: rtl/bessel_ctrl_pkg.sv
// rtl/bessel_ctrl_pkg.sv - shared state encoding and default parameters for the Bessel filter sequencer
package bessel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int ADC_WIDTH     = 14;
  localparam int B_WIDTH       = 16;
  localparam int B_DEFAULT     = 2158;
  localparam int FLUSH_CYCLES  = 4;
  localparam int SETTLE_CYCLES = 64;
  localparam int CNT_WIDTH     = 16;

endpackage

// File: rtl/bessel_filter_ctrl_if.sv
// rtl/bessel_filter_ctrl_if.sv - coefficient write bus between the config register bank and the sequencer
interface bessel_filter_ctrl_if #(
  parameter int B_WIDTH = 16
);

  logic [B_WIDTH-1:0] cfg_b;
  logic               cfg_wr;
  logic               cfg_ack;
  logic               cfg_err;

  modport master (
    output cfg_b,
    output cfg_wr,
    input  cfg_ack,
    input  cfg_err
  );

  modport slave (
    input  cfg_b,
    input  cfg_wr,
    output cfg_ack,
    output cfg_err
  );

endinterface

// File: rtl/bessel_ctrl_timer.sv
// rtl/bessel_ctrl_timer.sv - restartable saturating cycle counter shared by the FLUSH and SETTLE phases
module bessel_ctrl_timer #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [CNT_WIDTH-1:0] term,
  output logic                 done
);

  logic [CNT_WIDTH-1:0] count;

  // Holds at the terminal value instead of wrapping, so done stays asserted
  // until the owner restarts the phase.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (count != term) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == term);

endmodule

// File: rtl/bessel_filter_ctrl.sv
// rtl/bessel_filter_ctrl.sv - flush/settle sequencer and output gate for the Bessel low-pass core
// Optional macro BESSEL_CTRL_STATS_EN adds reconfig_count and settle_active outputs.
module bessel_filter_ctrl #(
  parameter int ADC_WIDTH     = bessel_ctrl_pkg::ADC_WIDTH,
  parameter int B_WIDTH       = bessel_ctrl_pkg::B_WIDTH,
  parameter int B_DEFAULT     = bessel_ctrl_pkg::B_DEFAULT,
  parameter int FLUSH_CYCLES  = bessel_ctrl_pkg::FLUSH_CYCLES,
  parameter int SETTLE_CYCLES = bessel_ctrl_pkg::SETTLE_CYCLES,
  parameter int CNT_WIDTH     = bessel_ctrl_pkg::CNT_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  bessel_filter_ctrl_if.slave         cfg,
  output logic                        busy,
  output logic [B_WIDTH-1:0]          filt_b,
  output logic                        filt_reset,
  input  logic signed [ADC_WIDTH-1:0] adc_dat_a,
  input  logic signed [ADC_WIDTH-1:0] adc_filt_a,
  output logic signed [ADC_WIDTH-1:0] adc_out,
  output logic                        out_valid
`ifdef BESSEL_CTRL_STATS_EN
  ,
  output logic [15:0]                 reconfig_count,
  output logic                        settle_active
`endif
);

  import bessel_ctrl_pkg::*;

  state_t               state;
  state_t               state_nxt;
  logic [B_WIDTH-1:0]   shadow;
  logic [B_WIDTH-1:0]   shadow_nxt;
  logic                 wr_ok;
  logic                 wr_bad;
  logic                 tmr_clear;
  logic                 tmr_done;
  logic                 load_b;
  logic [CNT_WIDTH-1:0] tmr_term;

  assign wr_ok      = cfg.cfg_wr && (cfg.cfg_b != '0);
  assign wr_bad     = cfg.cfg_wr && (cfg.cfg_b == '0);
  assign shadow_nxt = wr_ok ? cfg.cfg_b : shadow;
  assign tmr_term   = (state == SETTLE) ? CNT_WIDTH'(SETTLE_CYCLES - 1)
                                        : CNT_WIDTH'(FLUSH_CYCLES - 1);

  bessel_ctrl_timer #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clear (tmr_clear),
    .term  (tmr_term),
    .done  (tmr_done)
  );

  always_comb begin
    state_nxt = state;
    tmr_clear = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (wr_ok)         tmr_clear = 1'b1;
        else if (tmr_done) state_nxt = SETTLE;
      end
      SETTLE: begin
        if (wr_ok)         state_nxt = FLUSH;
        else if (tmr_done) state_nxt = RUN;
      end
      RUN: begin
        if (wr_ok) state_nxt = FLUSH;
      end
      default: state_nxt = IDLE;
    endcase
    if (!enable) state_nxt = IDLE;
    if ((state_nxt != state) || !enable) tmr_clear = 1'b1;
  end

  // The coefficient only moves while filt_reset is held: on FLUSH entry, or
  // on a fresh write that restarts an ongoing flush.
  assign load_b = (state_nxt == FLUSH) && ((state != FLUSH) || wr_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= B_WIDTH'(B_DEFAULT);
      filt_b      <= B_WIDTH'(B_DEFAULT);
      filt_reset  <= 1'b1;
      adc_out     <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      cfg.cfg_ack <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      shadow      <= shadow_nxt;
      cfg.cfg_ack <= wr_ok;
      cfg.cfg_err <= wr_bad;
      if (load_b) filt_b <= shadow_nxt;
      filt_reset  <= (state_nxt == IDLE) || (state_nxt == FLUSH);
      busy        <= (state_nxt == FLUSH) || (state_nxt == SETTLE);
      out_valid   <= (state_nxt == RUN);
      case (state_nxt)
        SETTLE:  adc_out <= adc_dat_a;
        RUN:     adc_out <= adc_filt_a;
        default: adc_out <= '0;
      endcase
    end
  end

`ifdef BESSEL_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      reconfig_count <= '0;
      settle_active  <= 1'b0;
    end else begin
      if (wr_ok && (reconfig_count != 16'hFFFF)) reconfig_count <= reconfig_count + 16'd1;
      settle_active <= (state_nxt == SETTLE);
    end
  end
`endif

endmodule
